// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester and its helpers.
package apb_pkg;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_t;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-cycle counter with synchronous clear; expired once LIMIT counts are reached.
module apb_wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expired = (count_q >= CNT_W'(LIMIT));

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/apb_master.sv
// APB requester: single commands from a valid/ready port run as SETUP/ACCESS transfers.
// Optional ACCESS timeout abort is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W      = APB_ADDR_W,
    parameter int unsigned DATA_W      = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PRWADDR,
    output logic [DATA_W-1:0] PRWDATA,
    input  logic [DATA_W-1:0] PRDATA1,
    input  logic              PREADY
);

    apb_state_t        state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef APB_MASTER_TIMEOUT_EN
    logic rsp_err_q, rsp_err_d;
    logic timer_clr;
    logic timer_en;
    logic timer_expired;

    apb_wait_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk     (PCLK),
        .rst_n   (PRESET),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    assign rsp_err = rsp_err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
        rsp_err_d   = 1'b0;
        timer_clr   = 1'b0;
        timer_en    = 1'b0;
`endif

        unique case (state_q)
            APB_IDLE: begin
                cmd_ready_d = 1'b1;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                if (cmd_valid && cmd_ready_q) begin
                    pwrite_d    = cmd_write;
                    paddr_d     = cmd_addr;
                    pwdata_d    = cmd_wdata;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    state_d     = APB_SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
                    timer_clr   = 1'b1;
`endif
                end
            end

            APB_SETUP: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                state_d   = APB_ACCESS;
            end

            APB_ACCESS: begin
                // A ready slave always wins over a timeout landing on the same edge.
                if (PREADY) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA1;
                    cmd_ready_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = APB_IDLE;
`ifdef APB_MASTER_TIMEOUT_EN
                end else if (timer_expired) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    cmd_ready_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = APB_IDLE;
                end else begin
                    timer_en = 1'b1;
`endif
                end
            end

            default: begin
                state_d     = APB_IDLE;
                cmd_ready_d = 1'b1;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q     <= APB_IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PRWADDR   = paddr_q;
    assign PRWDATA   = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: behavioural APB memory slave with programmable wait states,
// table of single transfers, scoreboard of expected responses, plus reset and back-to-back sequences.
module tb_apb_master;

    logic        PCLK;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PRWADDR;
    logic [31:0] PRWDATA;
    logic [31:0] PRDATA1;
    logic        PREADY;

    apb_master #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (16)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PRWADDR   (PRWADDR),
        .PRWDATA   (PRWDATA),
        .PRDATA1   (PRDATA1),
        .PREADY    (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // ---------------- slave model ----------------
    logic [31:0] mem [16];
    int          wait_cfg;
    int          acc_cnt;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h0000_0309;
        mem[1] = 32'h0712_2023;
        mem[2] = 32'h444F_4C5A;
    end

    assign PRDATA1 = mem[PRWADDR[3:0]];
    assign PREADY  = (acc_cnt >= wait_cfg);

    always @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            acc_cnt <= 0;
        end else if (PSEL && PENABLE) begin
            acc_cnt <= PREADY ? 0 : acc_cnt + 1;
            if (PREADY && PWRITE) mem[PRWADDR[3:0]] <= PRWDATA;
        end else begin
            acc_cnt <= 0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          accept;
        int          lat;
    } exp_t;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    exp_t exp_q[$];
    int   vectors;
    int   errors;
    int   cyc;
    int   rsp_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge PCLK) cyc <= cyc + 1;

    always @(negedge PCLK) begin
        if (PRESET) begin
            if (PENABLE && !PSEL) chk("penable_without_psel", 32'(PSEL), 32'd1);
            if (PSEL && exp_q.size() > 0) begin
                chk("pwrite_stable", 32'(PWRITE), 32'(exp_q[0].write));
                chk("paddr_stable", PRWADDR, exp_q[0].addr);
                chk("pwdata_stable", PRWDATA, exp_q[0].wdata);
            end
            if (rsp_valid) begin
                exp_t e;
                rsp_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("rsp_latency", 32'(cyc - e.accept), 32'(e.lat));
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic issue(input vec_t v, input logic exp_err, output int acc_edge);
        int guard;
        exp_t e;
        guard = 0;
        acc_edge = -1;
        @(negedge PCLK);
        wait_cfg  = v.waits;
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        while (!cmd_ready && guard < 100) begin
            @(negedge PCLK);
            guard++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
        end else begin
            e.write  = v.write;
            e.addr   = v.addr;
            e.wdata  = v.wdata;
            e.rdata  = v.rdata;
            e.err    = exp_err;
            e.accept = cyc + 1;
            e.lat    = v.lat;
            exp_q.push_back(e);
            acc_edge = e.accept;
        end
    endtask

    task automatic drop_valid();
        @(negedge PCLK);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            @(negedge PCLK);
            guard++;
        end
        if (exp_q.size() > 0) begin
            chk("response_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(negedge PCLK);
    endtask

    vec_t vecs[7];
    vec_t v;
    int   acc;
    int   acc_edges[4];
    int   rsp_before;

    initial begin
        vectors   = 0;
        errors    = 0;
        cyc       = 0;
        rsp_count = 0;
        wait_cfg  = 0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PRESET    = 1'b1;

        vecs[0] = '{1'b0, 32'd0, 32'h0000_0000, 0, 32'h0000_0309, 2};
        vecs[1] = '{1'b1, 32'd5, 32'hDEAD_BEEF, 0, 32'h0000_0000, 2};
        vecs[2] = '{1'b0, 32'd5, 32'h1111_2222, 0, 32'hDEAD_BEEF, 2};
        vecs[3] = '{1'b0, 32'd1, 32'h0000_0000, 3, 32'h0712_2023, 5};
        vecs[4] = '{1'b0, 32'd2, 32'hFFFF_FFFF, 1, 32'h444F_4C5A, 3};
        vecs[5] = '{1'b1, 32'd7, 32'h1234_5678, 2, 32'h0000_0000, 4};
        vecs[6] = '{1'b0, 32'd7, 32'h0000_0000, 0, 32'h1234_5678, 2};

        #1 PRESET = 1'b0;
        #2;
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_psel", 32'(PSEL), 32'd0);
        chk("reset_penable", 32'(PENABLE), 32'd0);
        chk("reset_pwrite", 32'(PWRITE), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_paddr", PRWADDR, 32'd0);
        chk("reset_pwdata", PRWDATA, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b1;

        for (int i = 0; i < 7; i++) begin
            issue(vecs[i], 1'b0, acc);
            drop_valid();
            drain();
        end

        // Reset while the slave stalls in ACCESS: bus drops immediately, no response.
        v = '{1'b0, 32'd3, 32'h0, 100, 32'h0, 2};
        issue(v, 1'b0, acc);
        drop_valid();
        begin
            int guard;
            guard = 0;
            while (!PENABLE && guard < 20) begin
                @(negedge PCLK);
                guard++;
            end
        end
        chk("reached_access", 32'(PENABLE), 32'd1);
        #2 PRESET = 1'b0;
        #1;
        chk("async_reset_psel", 32'(PSEL), 32'd0);
        chk("async_reset_penable", 32'(PENABLE), 32'd0);
        exp_q.delete();
        rsp_before = rsp_count;
        @(negedge PCLK);
        chk("reset_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        v = '{1'b0, 32'd2, 32'h0, 0, 32'h444F_4C5A, 2};
        issue(v, 1'b0, acc);
        drop_valid();
        drain();
        chk("reset_rsp_count", 32'(rsp_count - rsp_before), 32'd1);

        // Back-to-back: cmd_valid stays high for four commands.
        rsp_before = rsp_count;
        v = '{1'b0, 32'd0, 32'h0, 0, 32'h0000_0309, 2};
        issue(v, 1'b0, acc_edges[0]);
        v = '{1'b0, 32'd1, 32'h0, 0, 32'h0712_2023, 2};
        issue(v, 1'b0, acc_edges[1]);
        v = '{1'b0, 32'd2, 32'h0, 0, 32'h444F_4C5A, 2};
        issue(v, 1'b0, acc_edges[2]);
        v = '{1'b0, 32'd5, 32'h0, 0, 32'hDEAD_BEEF, 2};
        issue(v, 1'b0, acc_edges[3]);
        drop_valid();
        drain();
        for (int i = 1; i < 4; i++)
            chk("b2b_spacing", 32'(acc_edges[i] - acc_edges[i-1]), 32'd3);
        chk("b2b_rsp_count", 32'(rsp_count - rsp_before), 32'd4);

`ifdef APB_MASTER_TIMEOUT_EN
        v = '{1'b0, 32'd1, 32'h0, 1000, 32'h0, 18};
        issue(v, 1'b1, acc);
        drop_valid();
        drain();
        chk("timeout_psel_after", 32'(PSEL), 32'd0);
        wait_cfg = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/apb_master.md
# apb_master

APB requester that drives the bus side of the register/memory slaves in this design. It accepts single read or write commands from a local valid/ready command port and runs each one as a standard two-phase APB transfer: SETUP, then ACCESS, then waiting on PREADY. It returns read data, or a write completion, on a one-cycle response strobe. It sits between the test/control logic and the APB slave. It uses the slave's shared address bus `PRWADDR`, its write bus `PRWDATA` and its read bus `PRDATA1`.

## Interface
Parameters:
- `ADDR_W`, default 32: width of `PRWADDR` and `cmd_addr`.
- `DATA_W`, default 32: width of the data buses.
- `TIMEOUT_CYC`, default 16: number of ACCESS wait cycles before abort. Used only when the timeout macro is defined.

Ports:
- `PCLK` in 1: single clock, rising edge.
- `PRESET` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when high together with `cmd_valid`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in `ADDR_W`: transfer address.
- `cmd_wdata` in `DATA_W`: write data.
- `rsp_valid` out 1: one-cycle completion strobe.
- `rsp_rdata` out `DATA_W`: read data, valid while `rsp_valid` is high.
- `rsp_err` out 1: transfer aborted by timeout.
- `PSEL` out 1: APB select.
- `PENABLE` out 1: APB enable.
- `PWRITE` out 1: APB direction.
- `PRWADDR` out `ADDR_W`: APB address.
- `PRWDATA` out `DATA_W`: APB write data.
- `PRDATA1` in `DATA_W`: APB read data.
- `PREADY` in 1: slave ready.

## Operation
- The FSM has three states: IDLE, SETUP and ACCESS. All outputs are registered.
- **IDLE**
  - `cmd_ready`=1, `PSEL`=0, `PENABLE`=0.
  - On `cmd_valid & cmd_ready`: latch `cmd_write`, `cmd_addr` and `cmd_wdata` into `PWRITE`, `PRWADDR` and `PRWDATA`, then go to SETUP.
- **SETUP**
  - `PSEL`=1, `PENABLE`=0, `cmd_ready`=0.
  - Unconditionally go to ACCESS on the next edge.
- **ACCESS**
  - `PSEL`=1, `PENABLE`=1.
  - If `PREADY` is sampled high:
    - For a read, capture `PRDATA1` into `rsp_rdata`. For a write, `rsp_rdata` = 0.
    - Pulse `rsp_valid` for one cycle and go to IDLE.
  - If `PREADY` is sampled low, stay in ACCESS.
- `PWRITE`, `PRWADDR` and `PRWDATA` are stable from SETUP through the final ACCESS cycle. In IDLE they hold their last value.
- There is no response backpressure: the consumer must accept `rsp_valid` when it occurs.
- `PREADY` is ignored in IDLE and SETUP.
- Reset mid-transfer:
  - `PSEL` and `PENABLE` drop to 0 asynchronously and the FSM goes to IDLE.
  - No `rsp_valid` is issued for the interrupted command.

## Timing
- Reset values of all outputs:
  - `cmd_ready`=1 (once out of reset).
  - `PSEL`, `PENABLE`, `PWRITE`, `rsp_valid` and `rsp_err` = 0.
  - `PRWADDR`, `PRWDATA` and `rsp_rdata` = 0.
- Cycle-level sequence, with the command accepted at edge N:
  - SETUP is visible in cycle N..N+1.
  - ACCESS starts at edge N+1.
  - `PREADY` is first sampled at edge N+2.
  - `rsp_valid` is high in the cycle after edge N+2.
- Minimum latency, command accept to `rsp_valid`: 2 edges. Each wait cycle (`PREADY`=0) adds 1.
- Back-to-back commands:
  - `cmd_ready` is high again in the same cycle as `rsp_valid`.
  - A new command can be accepted at that edge.
  - Throughput is one transfer per 3 cycles.

## Configuration
- Macro: `APB_MASTER_TIMEOUT_EN`.
- **Defined**
  - A counter counts consecutive ACCESS cycles with `PREADY`=0. It clears on entry to SETUP.
  - When the count reaches `TIMEOUT_CYC` with `PREADY` still low: drop `PSEL` and `PENABLE`, go to IDLE, and pulse `rsp_valid` with `rsp_err`=1 and `rsp_rdata`=0.
  - `PREADY` sampled high on the same edge as the limit wins: normal completion, `rsp_err`=0.
- **Undefined**
  - ACCESS waits indefinitely.
  - `rsp_err` is tied to 0 and no counter is built.

## Structure
- Package `apb_pkg` holds:
  - The state enum `apb_state_t` {`APB_IDLE`, `APB_SETUP`, `APB_ACCESS`}.
  - Default width constants `APB_ADDR_W` = 32 and `APB_DATA_W` = 32.
- One sub-module, `apb_wait_timer`: a counter with clear, enable and an expired flag. It is instantiated only under `APB_MASTER_TIMEOUT_EN`.

## Test plan
- Read addr 0 from a reset-initialised slave -> `rsp_valid` 2 edges after accept, `rsp_rdata`=0x00000309, `rsp_err`=0.
- Write 0xDEADBEEF to addr 5, then read addr 5 -> write completes with `rsp_rdata`=0; read returns 0xDEADBEEF. `PWRITE`, `PRWADDR` and `PRWDATA` stay stable across SETUP and ACCESS.
- Slave holds `PREADY`=0 for 3 ACCESS cycles on a read of addr 1 -> `PSEL` and `PENABLE` are held, `rsp_valid` comes 5 edges after accept, data = 0x07122023.
- With `APB_MASTER_TIMEOUT_EN` and `TIMEOUT_CYC`=16, `PREADY` stuck at 0 -> abort after 16 wait cycles, `rsp_err`=1, `rsp_rdata`=0, `PSEL`=0 the next cycle.
- Assert `PRESET`=0 during ACCESS -> `PSEL` and `PENABLE` fall with no clock edge and no `rsp_valid`. After release, `cmd_ready`=1 and a read of addr 2 returns 0x444F4C5A.
- Keep `cmd_valid` high for 4 consecutive commands -> exactly 4 `rsp_valid` pulses, one every 3 cycles, in order.
